// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the CPU memory responder: IO register map,
// UART state encoding and read-data source select.
package mem_responder_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] IO_LEDS        = 3'd0;
    localparam logic [2:0] IO_UART_DATA   = 3'd1;
    localparam logic [2:0] IO_UART_STATUS = 3'd2;
    localparam logic [2:0] IO_CYCLES      = 3'd3;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_IO
    } rd_src_e;

endpackage

// File: rtl/mem_responder_uart_tx.sv
// 8N1 serial transmitter. A start pulse while idle latches one byte; busy stays
// high from the accepting edge through the last stop-bit cycle.
module uart_tx
    import mem_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    uart_state_e   state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          last;

    assign last = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= UART_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                UART_IDLE: begin
                    // Start is ignored unless idle, so writes while busy drop.
                    if (start) begin
                        state   <= UART_START;
                        shreg   <= data;
                        clk_cnt <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                UART_START: begin
                    if (last) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= UART_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                UART_DATA: begin
                    if (last) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= UART_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                UART_STOP: begin
                    if (last) begin
                        clk_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= UART_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory target for the CPU bus: byte-writable RAM plus an IO page
// holding LEDs, a free-running cycle counter and a UART transmitter.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int    RAM_WORDS    = 1536,
    parameter string INIT_FILE    = "",
    parameter int    CLKS_PER_BIT = 104,
    parameter int    IO_BIT       = 22
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [BUS_W-1:0] mem_addr,
    input  logic [BUS_W-1:0] mem_wdata,
    input  logic             mem_rstrb,
    input  logic [3:0]       mem_wmask,
    output logic [BUS_W-1:0] mem_rdata,
    output logic [7:0]       leds,
    output logic             uart_tx
);

    localparam int IDX_W = IO_BIT - 2;
    localparam int AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic             sel_io;
    logic [IDX_W-1:0] word_idx;
    logic [AW-1:0]    ram_addr;
    logic [2:0]       io_off;
    logic             in_ram;
    logic             ram_we;
    logic             led_we;
    logic             uart_start;
    logic             uart_busy;

    logic [BUS_W-1:0] ram [RAM_WORDS];
    logic [BUS_W-1:0] ram_q;
    logic [BUS_W-1:0] io_rd;
    logic [BUS_W-1:0] io_q;
    logic [BUS_W-1:0] cycles;
    rd_src_e          rd_src;

    logic unused;
    assign unused = ^{mem_addr[BUS_W-1:IO_BIT+1], mem_addr[1:0]};

    assign sel_io     = mem_addr[IO_BIT];
    assign word_idx   = mem_addr[IO_BIT-1:2];
    assign ram_addr   = word_idx[AW-1:0];
    assign io_off     = mem_addr[4:2];
    assign in_ram     = (32'(word_idx) < 32'(RAM_WORDS));
    assign ram_we     = (|mem_wmask) && !sel_io && in_ram;
    assign led_we     = sel_io && (io_off == IO_LEDS) && mem_wmask[0];
    assign uart_start = sel_io && (io_off == IO_UART_DATA) && mem_wmask[0];

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) ram[i] = '0;
    end

    // Plain clocked RAM with per-lane writes and an enabled registered read;
    // reads see the pre-write word on a same-cycle read/write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && mem_wmask[i]) ram[ram_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (mem_rstrb) ram_q <= ram[ram_addr];
    end

    always_comb begin
        io_rd = '0;
        case (io_off)
            IO_LEDS:        io_rd = {24'b0, leds};
            IO_UART_STATUS: io_rd = {31'b0, uart_busy};
            IO_CYCLES:      io_rd = cycles;
            default:        io_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_src <= RD_ZERO;
            io_q   <= '0;
            leds   <= '0;
            cycles <= '0;
        end else begin
            cycles <= cycles + 1'b1;
            if (mem_rstrb) begin
                rd_src <= sel_io ? RD_IO : (in_ram ? RD_RAM : RD_ZERO);
                io_q   <= io_rd;
            end
            if (led_we) leds <= mem_wdata[7:0];
        end
    end

    // Output is a select over registers only, so it still changes only at edges.
    always_comb begin
        mem_rdata = '0;
        case (rd_src)
            RD_RAM:  mem_rdata = ram_q;
            RD_IO:   mem_rdata = io_q;
            default: mem_rdata = '0;
        endcase
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .rstn (rstn),
        .start(uart_start),
        .data (mem_wdata[7:0]),
        .busy (uart_busy),
        .tx   (uart_tx)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed RAM/IO/UART/reset cases plus randomized
// RAM and LED traffic checked against a word-array reference model.
module tb_mem_responder;

    localparam int RW  = 1536;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_rstrb = 1'b0;
    logic [3:0]  mem_wmask = '0;
    logic [31:0] mem_rdata;
    logic [7:0]  leds;
    logic        uart_tx;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram_m [RW];
    logic [31:0] rd_m;
    logic [7:0]  leds_m;
    logic [31:0] cyc_m;
    logic [31:0] r1, r2;
    logic [9:0]  frame;

    mem_responder #(
        .RAM_WORDS(RW), .INIT_FILE(""), .CLKS_PER_BIT(CPB), .IO_BIT(22)
    ) dut (
        .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .leds(leds), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release: the value a CYCLES read must return.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc_m <= '0;
        else       cyc_m <= cyc_m + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: update the model, drive, clock, then check rdata and leds.
    task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic rs,
                      input logic [3:0] wm, input logic busy_e);
        logic       io;
        int         idx;
        logic [2:0] off;
        io  = a[22];
        idx = int'(a[21:2]);
        off = a[4:2];
        if (rs) begin
            if (!io) rd_m = (idx < RW) ? ram_m[idx] : 32'h0;
            else begin
                case (off)
                    3'd0:    rd_m = {24'h0, leds_m};
                    3'd2:    rd_m = {31'h0, busy_e};
                    3'd3:    rd_m = cyc_m;
                    default: rd_m = 32'h0;
                endcase
            end
        end
        if (wm != 4'h0) begin
            if (!io && idx < RW) begin
                for (int i = 0; i < 4; i++)
                    if (wm[i]) ram_m[idx][8*i +: 8] = wd[8*i +: 8];
            end else if (io && off == 3'd0 && wm[0]) begin
                leds_m = wd[7:0];
            end
        end
        mem_addr  = a;
        mem_wdata = wd;
        mem_rstrb = rs;
        mem_wmask = wm;
        @(posedge clk);
        #1;
        mem_rstrb = 1'b0;
        mem_wmask = 4'h0;
        chk("rdata", mem_rdata, rd_m);
        chk("leds", {24'h0, leds}, {24'h0, leds_m});
    endtask

    initial begin
        for (int i = 0; i < RW; i++) ram_m[i] = '0;
        rd_m   = '0;
        leds_m = '0;
        frame  = {1'b1, 8'h41, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_leds", {24'h0, leds}, 32'h0);
        chk("rst_tx", {31'h0, uart_tx}, 32'h1);
        rstn = 1'b1;

        // RAM word, byte lanes, hold
        op(32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 1'b0);
        op(32'h10, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("ram_word", mem_rdata, 32'hDEADBEEF);
        op(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        chk("ram_hold", mem_rdata, 32'hDEADBEEF);
        op(32'h10, 32'h55555555, 1'b0, 4'b0100, 1'b0);
        op(32'h10, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("lane2", mem_rdata, 32'hDE55BEEF);
        op(32'h10, 32'h12341234, 1'b0, 4'b0011, 1'b0);
        op(32'h10, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("lane01", mem_rdata, 32'hDE551234);

        // Same-cycle read and write
        op(32'h20, 32'h11111111, 1'b0, 4'hF, 1'b0);
        op(32'h20, 32'h22222222, 1'b1, 4'hF, 1'b0);
        chk("rw_old", mem_rdata, 32'h11111111);
        op(32'h20, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("rw_new", mem_rdata, 32'h22222222);

        // RAM bounds: last word usable, first word past the end reads 0
        op(32'd6140, 32'hCAFEF00D, 1'b0, 4'hF, 1'b0);
        op(32'd6140, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("last_word", mem_rdata, 32'hCAFEF00D);
        op(32'd6144, 32'h12345678, 1'b0, 4'hF, 1'b0);
        op(32'd6144, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("past_end", mem_rdata, 32'h0);

        // IO page
        op(32'h00400000, 32'h000000A5, 1'b0, 4'h1, 1'b0);
        chk("leds_wr", {24'h0, leds}, 32'hA5);
        op(32'h00400000, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("leds_rd", mem_rdata, 32'hA5);
        op(32'h0040000C, 32'h0, 1'b1, 4'h0, 1'b0);
        r1 = mem_rdata;
        repeat (7) op(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        op(32'h0040000C, 32'h0, 1'b1, 4'h0, 1'b0);
        r2 = mem_rdata;
        chk("cyc_diff", r2 - r1, 32'd8);
        op(32'h00400014, 32'hFFFFFFFF, 1'b1, 4'hF, 1'b0);
        chk("off5", mem_rdata, 32'h0);

        // UART frame of 0x41, with a status read and a dropped write mid-frame
        op(32'h00400004, 32'h00000041, 1'b0, 4'h1, 1'b0);
        for (int c = 0; c < 10 * CPB; c++) begin
            chk($sformatf("tx_%0d", c), {31'h0, uart_tx}, {31'h0, frame[c/CPB]});
            if (c == 5) begin
                op(32'h00400008, 32'h0, 1'b1, 4'h0, 1'b1);
                chk("busy_mid", mem_rdata, 32'h1);
            end else if (c == 10) begin
                op(32'h00400004, 32'h000000FF, 1'b0, 4'h1, 1'b1);
            end else begin
                op(32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
            end
        end
        op(32'h00400008, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("busy_done", mem_rdata, 32'h0);
        for (int c = 0; c < 2 * CPB; c++) begin
            chk("tx_idle", {31'h0, uart_tx}, 32'h1);
            op(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        end

        // Randomized RAM / IO traffic (UART data register never written)
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [3:0]  wm;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       a = {20'h0, 4'($urandom_range(0, 15)), 6'h0, 2'($urandom)} >> 4;
            else if (sel == 6) a = 32'd6140 | 32'($urandom_range(0, 3));
            else if (sel == 7) a = 32'd6144 + 32'($urandom_range(0, 15));
            else               a = 32'h00400000 | (32'($urandom_range(0, 7)) << 2);
            wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            if (a[22] && a[4:2] == 3'd1) wm = 4'h0;
            op(a, $urandom, 1'($urandom), wm, 1'b0);
        end

        // Reset in the middle of a frame
        op(32'h00400000, 32'h0000003C, 1'b0, 4'h1, 1'b0);
        op(32'h00400004, 32'h00000041, 1'b0, 4'h1, 1'b0);
        op(32'h10, 32'h0, 1'b1, 4'h0, 1'b1);
        repeat (12) op(32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
        rstn = 1'b0;
        #2;
        chk("mrst_tx", {31'h0, uart_tx}, 32'h1);
        chk("mrst_leds", {24'h0, leds}, 32'h0);
        chk("mrst_rdata", mem_rdata, 32'h0);
        rd_m   = '0;
        leds_m = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        op(32'h00400008, 32'h0, 1'b1, 4'h0, 1'b0);
        chk("mrst_busy", mem_rdata, 32'h0);
        for (int c = 0; c < 3 * CPB; c++) begin
            chk("mrst_tx_idle", {31'h0, uart_tx}, 32'h1);
            op(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        end
        op(32'h10, 32'h0, 1'b1, 4'h0, 1'b0);
        op(32'h0040000C, 32'h0, 1'b1, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
